// File: rtl/btb_update_ctrl_pkg.sv
// Shared encodings for the BTB update controller and its history table.
package btb_update_ctrl_pkg;

    // Command encodings driven onto the BTB command port
    localparam logic [1:0] BTB_NOP   = 2'b00;
    localparam logic [1:0] BTB_INVAL = 2'b01;
    localparam logic [1:0] BTB_WRITE = 2'b10;

    // Two-bit saturating counter values
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Index is taken from the word-aligned PC, starting at bit 2
    localparam int IDX_LSB     = 2;
    localparam int IDX_W_DFLT  = 4;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/btb_update_ctrl_bht.sv
// Branch history table: one 2-bit saturating counter per BTB index.
module bht_2bit
    import btb_update_ctrl_pkg::*;
#(
    parameter int IDX_W = IDX_W_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic             upd_en_i,
    input  logic             taken_i,
    output logic [1:0]       cnt_o
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cur;

    assign cur = cnt_q[rd_idx_i];

    // Saturating step of the addressed counter toward the actual outcome
    always_comb begin
        cnt_o = cur;
        if (taken_i) begin
            cnt_o = (cur == ST) ? ST : cur + 2'd1;
        end else begin
            cnt_o = (cur == SNT) ? SNT : cur - 2'd1;
        end
    end

    // Counter array: weakly not-taken after reset, written once per accepted branch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (upd_en_i) begin
            cnt_q[rd_idx_i] <= cnt_o;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Branch-resolution controller: redirect on misprediction, BHT update,
// BTB write/invalidate sequencing and an invalidate sweep after reset.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int IDX_W = IDX_W_DFLT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_hit,
    input  logic [31:0]      ex_pred_pc,
    output logic [1:0]       btb_cmd,
    output logic [31:0]      btb_pc,
    output logic [31:0]      btb_npc,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      npc_q, npc_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] mis_q, mis_d;

    logic             sweeping;
    logic             accept;
    logic             mis;
    logic [1:0]       cnt_nxt;
    logic [31:0]      sweep_pc;

    // Reset counts as busy so a branch in the reset cycle has no side effects
    assign busy     = !rst_n || (state_q == INIT);
    assign sweeping = rst_n && (state_q == INIT);
    assign accept   = ex_valid && !busy;
    assign sweep_pc = 32'(idx_q) << IDX_LSB;

    assign mis = (ex_taken != ex_pred_hit) ||
                 (ex_taken && ex_pred_hit && (ex_target != ex_pred_pc));

    assign redirect    = accept && mis;
    assign redirect_pc = redirect ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'd0;

    // The sweep drives the BTB directly so it lines up with busy; afterwards
    // the registered command is presented.
    assign btb_cmd = sweeping ? BTB_INVAL : cmd_q;
    assign btb_pc  = sweeping ? sweep_pc  : pc_q;
    assign btb_npc = npc_q;
    assign br_cnt  = br_q;
    assign mis_cnt = mis_q;

    bht_2bit #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx_i (ex_pc[IDX_W+1:IDX_LSB]),
        .upd_en_i (accept),
        .taken_i  (ex_taken),
        .cnt_o    (cnt_nxt)
    );

    // Sweep sequencing: walk every index once, then run
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == INIT) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == {IDX_W{1'b1}}) begin
                state_d = RUN;
            end
        end
    end

    // BTB command selection from the updated counter, plus performance counters
    always_comb begin
        cmd_d = BTB_NOP;
        pc_d  = pc_q;
        npc_d = npc_q;
        br_d  = br_q;
        mis_d = mis_q;
        if (accept) begin
            br_d = br_q + CNT_W'(1);
            if (mis) begin
                mis_d = mis_q + CNT_W'(1);
            end
            if (ex_taken && (cnt_nxt >= WT)) begin
                cmd_d = BTB_WRITE;
                pc_d  = ex_pc;
                npc_d = ex_target;
            end else if ((cnt_nxt <= WNT) && ex_pred_hit) begin
                cmd_d = BTB_INVAL;
                pc_d  = ex_pc;
            end
        end
    end

    // State registers; reset drops any pending command and restarts the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            idx_q   <= '0;
            cmd_q   <= BTB_NOP;
            pc_q    <= '0;
            npc_q   <= '0;
            br_q    <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

endmodule
